// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multicycle_alu block:
//     ALU_OP_W       width of the ALUControl operation code
//     alu_op_e       operation codes (13..15 are reserved/illegal)
//     alu_state_e    control FSM states (IDLE, BUSY, DONE)
//     is_multicycle  1 for the iterative ops (MUL, DIVU, REMU)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLTU  = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_REMU  = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
//   Iterative datapath for MUL / DIVU / REMU, one bit per i_step cycle.
//   The owning FSM pulses i_start when a request is accepted and asserts
//   i_step for exactly WIDTH cycles. o_result is the value the registers
//   will hold *after* the current step, so the owner can capture the final
//   answer on the same edge as the last step.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     i_start       load operands and clear the partial registers
//     i_step        perform one iteration
//     i_op          operation code (only MUL/DIVU/REMU are meaningful)
//     i_a, i_b      operands, sampled on i_start
//     o_result      result after the current step
//     o_mul_ovf     (MULTICYCLE_ALU_OVERFLOW_EN only) high half of the
//                   product after the current step is non-zero
// -----------------------------------------------------------------------------
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_step,
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  output logic                o_mul_ovf,
`endif
  output logic [WIDTH-1:0]    o_result
);

  // r_hi : high half of the partial product (MUL) / partial remainder (DIV)
  // r_lo : multiplier shifting out + low product bits shifting in (MUL),
  //        dividend shifting out + quotient bits shifting in (DIV)
  // r_opnd : multiplicand (MUL) or divisor (DIV)
  logic             r_mode_mul;
  logic             r_mode_rem;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  always_comb begin
    // Shift-add multiply: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift {hi, lo} right by one.
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    // Restoring divide: bring the next dividend bit into the remainder.
    // The remainder is always below the divisor, so the difference fits
    // in WIDTH bits whenever the subtraction is taken. A zero divisor
    // always "fits", yielding an all-ones quotient and remainder == dividend.
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opnd});
    w_diff  = w_shift[WIDTH-1:0] - r_opnd;
    if (r_mode_mul) begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_mul <= 1'b0;
      r_mode_rem <= 1'b0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else if (i_start) begin
      r_mode_mul <= (i_op == OP_MUL);
      r_mode_rem <= (i_op == OP_REMU);
      r_opnd     <= (i_op == OP_MUL) ? i_a : i_b;
      r_hi       <= '0;
      r_lo       <= (i_op == OP_MUL) ? i_b : i_a;
    end else if (i_step) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign o_result = r_mode_rem ? w_hi_nxt : w_lo_nxt;

`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  assign o_mul_ovf = r_mode_mul && (w_hi_nxt != '0);
`endif

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   Registered ALU. Single-cycle ops (ADD..SRA, illegal codes) load the
//   result one cycle after acceptance; MUL/DIVU/REMU iterate WIDTH steps in
//   seq_muldiv and load the result WIDTH+1 cycles after acceptance.
//
//   Optional build macro: MULTICYCLE_ALU_OVERFLOW_EN adds the Overflow output
//   (signed overflow for ADD/SUB, product wider than WIDTH for MUL).
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     InValid / InReady    request handshake (SrcA, SrcB, ALUControl)
//     SrcA, SrcB           operands
//     ALUControl           operation code (alu_op_e)
//     OutValid / OutReady  result handshake (ALUResult, Zero[, Overflow])
//     ALUResult            registered result
//     Zero                 registered (ALUResult == 0)
//     Overflow             optional, registered with ALUResult
//
//   Handshake: a request is taken on a rising edge where InValid && InReady;
//   operands and op are sampled only on that edge. A result is handed over on
//   a rising edge where OutValid && OutReady; until then OutValid, ALUResult
//   and Zero hold. InReady is high only in IDLE and OutValid only in DONE, so
//   requests arriving while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [WIDTH-1:0]    SrcA,
  input  logic [WIDTH-1:0]    SrcB,
  input  logic [ALU_OP_W-1:0] ALUControl,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [WIDTH-1:0]    ALUResult,
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  output logic                Overflow,
`endif
  output logic                Zero
);

  localparam int              CNT_W     = $clog2(WIDTH + 1);
  localparam int              SH_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  alu_op_e          w_op;
  logic             w_is_mc;
  logic             w_start;
  logic             w_step;
  logic             w_load_sc;
  logic             w_load_md;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_sc_result;
  logic [WIDTH-1:0] w_md_result;

  assign w_op    = alu_op_e'(ALUControl);
  assign w_is_mc = is_multicycle(w_op);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    InReady     = 1'b0;
    OutValid    = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_load_sc   = 1'b0;
    w_load_md   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          if (w_is_mc) begin
            w_start     = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            w_load_sc   = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        // The WIDTH-th step happens on this edge; capture its result now.
        if (r_cnt == LAST_STEP) begin
          w_load_md   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        OutValid = 1'b1;
        if (OutReady) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Step counter: cleared on acceptance, counts completed BUSY steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sum       = SrcA + SrcB;
    w_diff      = SrcA - SrcB;
    w_shamt     = SrcB[SH_W-1:0];
    w_sc_result = '0;
    case (w_op)
      OP_ADD:  w_sc_result = w_sum;
      OP_SUB:  w_sc_result = w_diff;
      OP_AND:  w_sc_result = SrcA & SrcB;
      OP_OR:   w_sc_result = SrcA | SrcB;
      OP_XOR:  w_sc_result = SrcA ^ SrcB;
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL:  w_sc_result = SrcA << w_shamt;
      OP_SRL:  w_sc_result = SrcA >> w_shamt;
      OP_SRA:  w_sc_result = $signed(SrcA) >>> w_shamt;
      default: w_sc_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath
  // ---------------------------------------------------------------------------
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  logic w_md_ovf;
  logic w_sc_ovf;
  logic r_ovf;

  always_comb begin
    w_sc_ovf = 1'b0;
    // Signed overflow: result sign differs from what the operand signs allow.
    if (w_op == OP_ADD) begin
      w_sc_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
    end else if (w_op == OP_SUB) begin
      w_sc_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
    end
  end
`endif

  seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_seq_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_step    (w_step),
    .i_op      (ALUControl),
    .i_a       (SrcA),
    .i_b       (SrcB),
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    .o_mul_ovf (w_md_ovf),
`endif
    .o_result  (w_md_result)
  );

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_load_sc) begin
      r_result <= w_sc_result;
      r_zero   <= (w_sc_result == '0);
    end else if (w_load_md) begin
      r_result <= w_md_result;
      r_zero   <= (w_md_result == '0);
    end
  end

`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_load_sc) begin
      r_ovf <= w_sc_ovf;
    end else if (w_load_md) begin
      r_ovf <= w_md_ovf;
    end
  end

  assign Overflow = r_ovf;
`endif

  assign ALUResult = r_result;
  assign Zero      = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//   Directed vector table and corner sequences on a WIDTH=32 instance,
//   randomized traffic on a WIDTH=8 instance against a reference model.
//   Optional build macro: MULTICYCLE_ALU_OVERFLOW_EN (also checks Overflow).
// -----------------------------------------------------------------------------
module tb_multicycle_alu;
  import alu_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32, zero32;
  logic [31:0] src_a32, src_b32, result32;
  logic [3:0]  ctrl32;
  // WIDTH=8 instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]  src_a8, src_b8, result8;
  logic [3:0]  ctrl8;
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
  logic        ovf32, ovf8;
`endif

  multicycle_alu #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .InValid    (in_valid32),
    .InReady    (in_ready32),
    .SrcA       (src_a32),
    .SrcB       (src_b32),
    .ALUControl (ctrl32),
    .OutValid   (out_valid32),
    .OutReady   (out_ready32),
    .ALUResult  (result32),
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    .Overflow   (ovf32),
`endif
    .Zero       (zero32)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .InValid    (in_valid8),
    .InReady    (in_ready8),
    .SrcA       (src_a8),
    .SrcB       (src_b8),
    .ALUControl (ctrl8),
    .OutValid   (out_valid8),
    .OutReady   (out_ready8),
    .ALUResult  (result8),
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    .Overflow   (ovf8),
`endif
    .Zero       (zero8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];  // WIDTH=8 expectations: {overflow, result}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for the WIDTH=8 instance, plain integer arithmetic.
  function automatic logic [8:0] ref8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int sh = int'(b % 8);
    int r = 0;
    logic v = 1'b0;
    case (op)
      4'd0:  begin r = int'(ua + ub); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1:  begin r = int'(ua - ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2:  r = int'(ua & ub);
      4'd3:  r = int'(ua | ub);
      4'd4:  r = int'(ua ^ ub);
      4'd5:  r = (ua < ub) ? 1 : 0;
      4'd6:  r = (sa < sb) ? 1 : 0;
      4'd7:  r = int'(ua << sh);
      4'd8:  r = int'(ua >> sh);
      4'd9:  r = sa >>> sh;
      4'd10: begin r = int'(ua * ub); v = (ua * ub > 255); end
      4'd11: r = (ub == 0) ? 255 : int'(ua / ub);
      4'd12: r = (ub == 0) ? int'(ua) : int'(ua % ub);
      default: r = 0;
    endcase
    return {v, 8'(r)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver for the WIDTH=32 instance: issue one request, return the latency
  // (acceptance edge counted as 1) and the first valid result.
  // ---------------------------------------------------------------------------
  task automatic run_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic z, output logic ovf);
    int guard = 0;
    @(negedge clk);
    while (!in_ready32 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid32 = 1'b1;
    ctrl32     = op;
    src_a32    = a;
    src_b32    = b;
    @(posedge clk);
    #1;
    // Scramble the inputs: they must not matter after acceptance.
    in_valid32 = 1'b0;
    src_a32    = $urandom;
    src_b32    = $urandom;
    ctrl32     = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result32;
    z   = zero32;
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    ovf = ovf32;
`else
    ovf = 1'b0;
`endif
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic ovf, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.exp_res = res; v.exp_ovf = ovf; v.exp_lat = lat;
    return v;
  endfunction

  // Watchdog: the run must always reach its summary.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  initial begin
    int          lat;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    int          seen;

    vecs.push_back(mk("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1));
    vecs.push_back(mk("sub",       4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1));
    vecs.push_back(mk("sub_ovf",   4'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1));
    vecs.push_back(mk("and",       4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1));
    vecs.push_back(mk("or",        4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1));
    vecs.push_back(mk("xor",       4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1));
    vecs.push_back(mk("slt",       4'd6,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1));
    vecs.push_back(mk("sltu",      4'd5,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1));
    vecs.push_back(mk("sll",       4'd7,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk("srl",       4'd8,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1));
    vecs.push_back(mk("sra_amt36", 4'd9,  32'h8000_0000, 32'd36,        32'hF800_0000, 1'b0, 1));
    vecs.push_back(mk("mul_2p32",  4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1, 33));
    vecs.push_back(mk("mul_ones",  4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b1, 33));
    vecs.push_back(mk("mul_small", 4'd10, 32'd1234,      32'd5678,      32'd7006652,   1'b0, 33));
    vecs.push_back(mk("divu",      4'd11, 32'd100,       32'd7,         32'd14,        1'b0, 33));
    vecs.push_back(mk("remu",      4'd12, 32'd100,       32'd7,         32'd2,         1'b0, 33));
    vecs.push_back(mk("divu_by0",  4'd11, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk("remu_by0",  4'd12, 32'd5,         32'd0,         32'd5,         1'b0, 33));
    vecs.push_back(mk("divu_big",  4'd11, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 1'b0, 33));
    vecs.push_back(mk("ill14",     4'd14, 32'd1234,      32'd5678,      32'd0,         1'b0, 1));
    vecs.push_back(mk("ill15",     4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, 1));

    // Reset state
    rst_n = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; src_a32 = '0; src_b32 = '0; ctrl32 = '0;
    in_valid8  = 1'b0; out_ready8  = 1'b1; src_a8  = '0; src_b8  = '0; ctrl8  = '0;
    #12;
    check("reset32_inready",  in_ready32,  1);
    check("reset32_outvalid", out_valid32, 0);
    check("reset32_result",   result32,    0);
    check("reset32_zero",     zero32,      0);
    check("reset8_inready",   in_ready8,   1);
    check("reset8_outvalid",  out_valid8,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, OutReady held high
    for (int i = 0; i < vecs.size(); i++) begin
      run_op32(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z, ovf);
      check($sformatf("%s_res", vecs[i].name),  res, vecs[i].exp_res);
      check($sformatf("%s_zero", vecs[i].name), z,   (vecs[i].exp_res == 32'd0));
      check($sformatf("%s_lat", vecs[i].name),  lat, vecs[i].exp_lat);
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
      check($sformatf("%s_ovf", vecs[i].name),  ovf, vecs[i].exp_ovf);
`endif
    end

    // Back-to-back: initiation interval of two cycles with OutReady high
    run_op32(4'd0, 32'd1, 32'd2, lat, res, z, ovf);
    @(posedge clk); #1;
    check("ii_idle_after_transfer", in_ready32, 1);

    // Backpressure: result must hold, new requests ignored
    out_ready32 = 1'b0;
    run_op32(4'd9, 32'h8000_0000, 32'd4, lat, res, z, ovf);
    check("bp_sra_res", res, 32'hF800_0000);
    check("bp_sra_lat", lat, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid32 = 1'b1; ctrl32 = 4'd0; src_a32 = 32'd1; src_b32 = 32'd1;
      @(posedge clk); #1;
      check("bp_hold_res",     result32,    32'hF800_0000);
      check("bp_hold_valid",   out_valid32, 1);
      check("bp_hold_inready", in_ready32,  0);
    end
    @(negedge clk);
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_inready",  in_ready32,  1);
    check("bp_release_outvalid", out_valid32, 0);
    @(posedge clk); #1;
    check("bp_not_queued", out_valid32, 0);

    // Reset in the middle of a DIVU
    @(negedge clk);
    in_valid32 = 1'b1; ctrl32 = 4'd11; src_a32 = 32'd100; src_b32 = 32'd7;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_inready", in_ready32, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inready",  in_ready32,  1);
    check("mid_rst_outvalid", out_valid32, 0);
    check("mid_rst_result",   result32,    0);
    check("mid_rst_zero",     zero32,      0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    check("mid_rst_no_result", seen, 0);

    // Random traffic on the WIDTH=8 instance
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      in_valid8  = ($urandom_range(0, 2) != 0);
      ctrl8      = 4'($urandom_range(0, 15));
      src_a8     = 8'($urandom);
      src_b8     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (in_valid8 && in_ready8) exp_q.push_back(ref8(ctrl8, src_a8, src_b8));
      if (exp_q.size() == 0) begin
        check("rnd_spurious_valid", out_valid8, 0);
      end else if (out_valid8) begin
        check("rnd_res",  result8, exp_q[0][7:0]);
        check("rnd_zero", zero8,   (exp_q[0][7:0] == 8'd0));
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
        check("rnd_ovf",  ovf8,    exp_q[0][8]);
`endif
        if (out_ready8) void'(exp_q.pop_front());
      end
    end
    // Drain
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      if (out_valid8) begin
        check("drain_res", result8, exp_q[0][7:0]);
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    check("rnd_drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered ALU for the next-generation datapath.
- Single-cycle ops (add/sub/logic/compare/shift) complete in one cycle. MUL, DIVU and REMU run iteratively over WIDTH cycles.
- Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake. This lets the control unit stall on long ops instead of widening the critical path.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- InValid  input  1  operand/op request valid
- InReady  output  1  block can accept a request
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- ALUControl  input  4  operation code (alu_op_e)
- OutValid  output  1  ALUResult/Zero valid
- OutReady  input  1  consumer accepts result
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered (ALUResult == 0)

Behaviour:
- Reset (async, rst_n low): state IDLE, InReady 1, OutValid 0, ALUResult 0, Zero 0, counter 0, internal operand registers 0. Reset asserted mid-operation aborts it; no result is ever emitted for it.
- Handshake rules:
  - Request accepted on a rising edge with InValid && InReady.
  - SrcA, SrcB and ALUControl are sampled only at acceptance; changes afterwards are ignored.
  - Result transferred on an edge with OutValid && OutReady.
  - OutValid, ALUResult and Zero hold stable until that transfer.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLTU (unsigned compare, result 1/0), 6 SLT (signed)
  - 7 SLL, 8 SRL, 9 SRA; shift amount is SrcB[$clog2(WIDTH)-1:0]
  - 10 MUL (low WIDTH bits of the product), 11 DIVU, 12 REMU
  - 13..15 are illegal: single-cycle, result 0, Zero 1.
- Arithmetic: modulo 2^WIDTH, no carry-out.
- Divide by zero: DIVU returns all ones; REMU returns SrcA. Latency is unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: InReady=1. On acceptance of a single-cycle op, compute and load ALUResult/Zero, then go to DONE. On acceptance of MUL/DIVU/REMU, latch the operands, clear the counter, then go to BUSY.
  - BUSY: InReady=0. One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. When the counter reaches WIDTH-1, load the result and go to DONE.
  - DONE: OutValid=1, InReady=0. On OutReady, go to IDLE.
- OutReady held high: the next request is accepted on the following IDLE cycle, giving a two-cycle minimum initiation interval.
- Latency from acceptance edge to OutValid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Zero always matches the loaded ALUResult.
- OutReady while OutValid=0 is ignored. InValid while InReady=0 is ignored and the request is not queued.

Optional Feature:
- Macro: MULTICYCLE_ALU_OVERFLOW_EN.
- When defined: adds output port Overflow (1 bit), registered with ALUResult, reset 0.
  - Set for signed overflow on ADD/SUB.
  - Set for MUL when the full 2*WIDTH product does not fit in WIDTH unsigned bits.
  - 0 for all other ops.
- When undefined: no port, no extra logic.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e, 4-bit enum of the codes above
  - alu_state_e enum (IDLE, BUSY, DONE)
  - function is_multicycle(alu_op_e)
  - constant ALU_OP_W = 4
- Sub-module seq_muldiv: iterative datapath for MUL/DIVU/REMU.
  - Contains the partial product, remainder and quotient registers.
  - Start/step inputs, result output.
  - The top module owns the FSM, counter and handshake.

Test Plan:
- Reset mid-BUSY: accept DIVU 100/7, assert rst_n low at cycle 5 → InReady 1, OutValid 0, ALUResult 0 immediately; no later result appears.
- WIDTH=32, OutReady=1: ADD 0xFFFFFFFF+1 → OutValid 1 cycle after acceptance, ALUResult 0, Zero 1; SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0.
- MUL 0x00010000*0x00010000 → OutValid exactly 33 cycles after acceptance, ALUResult 0, Zero 1. With the overflow macro defined, Overflow 1.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; each with 33-cycle latency.
- Backpressure: hold OutReady=0 for 10 cycles after SRA 0x80000000 by 4 → ALUResult 0xF8000000 stable, InReady 0, new InValid ignored. Release OutReady → IDLE next cycle.
- Illegal op 14 → ALUResult 0, Zero 1, 1-cycle latency. Sweep WIDTH=8 with random ops against a reference model.
